rv32i_writeback: RTL and testbench

RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

---
 rtl/rv32i_writeback.sv | 180 ++++++++++++++++++
 tb/tb_rv32i_writeback.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: retires ALU results, waits on memory read data for loads,
// and turns exceptions and branches into a one-cycle fetch redirect with upstream flush.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module rv32i_writeback #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_ce,
    input  logic                        i_stall,
    input  logic                        i_flush,
    input  logic [4:0]                  i_rd_addr,
    input  logic [31:0]                 i_rd,
    input  logic                        i_wr_rd,
    input  logic                        i_rd_valid,
    input  logic [`OPCODE_WIDTH-1:0]    i_opcode,
    input  logic [2:0]                  i_funct3,
    input  logic [`EXCEPTION_WIDTH-1:0] i_exception,
    input  logic                        i_change_pc,
    input  logic [31:0]                 i_next_pc,
    input  logic [1:0]                  i_addr_lsb,
    input  logic [31:0]                 i_load_data,
    input  logic                        i_ack,
    output logic                        o_wr_rd,
    output logic [4:0]                  o_rd_addr,
    output logic [31:0]                 o_rd,
    output logic                        o_change_pc,
    output logic [31:0]                 o_next_pc,
    output logic                        o_flush,
    output logic                        o_stall,
    output logic                        o_trap,
    output logic [31:0]                 o_instret
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_wr_rd;
    logic        r_change_pc;
    logic        r_flush;
    logic        r_trap;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rd;
    logic [31:0] r_next_pc;
    logic [31:0] r_instret;
    logic        r_load_wr;
    logic [4:0]  r_load_rd_addr;
    logic [2:0]  r_load_funct3;
    logic [1:0]  r_load_lsb;

    logic        w_has_exception;
    logic        w_is_load;
    logic        w_alu_write;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_value;
    logic        w_unused_opcode;

    assign w_has_exception = |i_exception;
    assign w_is_load       = i_opcode[`LOAD];
    assign w_alu_write     = i_wr_rd && i_rd_valid && (i_rd_addr != 5'd0);
    // Only the load bit steers this stage; the rest of the one-hot opcode is informational.
    assign w_unused_opcode = ^{i_opcode[`OPCODE_WIDTH-1:`LOAD+1], i_opcode[`LOAD-1:0]};

    assign w_byte = i_load_data[{r_load_lsb, 3'b000} +: 8];
    assign w_half = i_load_data[{r_load_lsb[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: assign a default before the case so no path can infer a latch.
        w_load_value = i_load_data;
        case (r_load_funct3)
            3'b000:  w_load_value = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_value = {24'd0, w_byte};
            3'b001:  w_load_value = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_value = {16'd0, w_half};
            default: w_load_value = i_load_data;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_wr_rd        <= 1'b0;
            r_change_pc    <= 1'b0;
            r_flush        <= 1'b0;
            r_trap         <= 1'b0;
            r_rd_addr      <= 5'd0;
            r_rd           <= 32'd0;
            r_next_pc      <= 32'd0;
            r_instret      <= 32'd0;
            r_load_wr      <= 1'b0;
            r_load_rd_addr <= 5'd0;
            r_load_funct3  <= 3'd0;
            r_load_lsb     <= 2'd0;
        end else if (i_flush) begin
            // Flush discards whatever is held, including a load still waiting on memory.
            r_state     <= IDLE;
            r_wr_rd     <= 1'b0;
            r_change_pc <= 1'b0;
            r_flush     <= 1'b0;
            r_trap      <= 1'b0;
        end else if (!i_stall) begin
            r_wr_rd     <= 1'b0;
            r_change_pc <= 1'b0;
            r_flush     <= 1'b0;
            r_trap      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_ce) begin
                        if (w_has_exception) begin
                            r_trap      <= 1'b1;
                            r_change_pc <= 1'b1;
                            r_flush     <= 1'b1;
                            r_next_pc   <= TRAP_VECTOR;
                            r_state     <= REDIRECT;
                        end else if (w_is_load) begin
                            r_load_wr      <= i_wr_rd && (i_rd_addr != 5'd0);
                            r_load_rd_addr <= i_rd_addr;
                            r_load_funct3  <= i_funct3;
                            r_load_lsb     <= i_addr_lsb;
                            r_state        <= LOAD_WAIT;
                        end else begin
                            if (w_alu_write) begin
                                r_wr_rd   <= 1'b1;
                                r_rd_addr <= i_rd_addr;
                                r_rd      <= i_rd;
                            end
                            r_instret <= r_instret + 32'd1;
                            if (i_change_pc) begin
                                r_change_pc <= 1'b1;
                                r_flush     <= 1'b1;
                                r_next_pc   <= i_next_pc;
                                r_state     <= REDIRECT;
                            end
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (i_ack) begin
                        if (r_load_wr) begin
                            r_wr_rd   <= 1'b1;
                            r_rd_addr <= r_load_rd_addr;
                            r_rd      <= w_load_value;
                        end
                        r_instret <= r_instret + 32'd1;
                        r_state   <= IDLE;
                    end
                end
                REDIRECT: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    assign o_wr_rd     = r_wr_rd;
    assign o_rd_addr   = r_rd_addr;
    assign o_rd        = r_rd;
    assign o_change_pc = r_change_pc;
    assign o_next_pc   = r_next_pc;
    assign o_flush     = r_flush;
    assign o_trap      = r_trap;
    assign o_instret   = r_instret;
    assign o_stall     = (r_state == LOAD_WAIT);

endmodule

// File: tb/tb_rv32i_writeback.sv
// Scoreboard bench for rv32i_writeback: a driver issues directed and random instructions and
// queues the expected writeback/redirect events; a monitor pops them as the stage presents them.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef JAL
`define JAL 5
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module tb_rv32i_writeback;

    localparam logic [31:0] TRAP_VEC = 32'h0000_0004;

    logic                        i_clk = 1'b0;
    logic                        i_rst;
    logic                        i_ce;
    logic                        i_stall;
    logic                        i_flush;
    logic [4:0]                  i_rd_addr;
    logic [31:0]                 i_rd;
    logic                        i_wr_rd;
    logic                        i_rd_valid;
    logic [`OPCODE_WIDTH-1:0]    i_opcode;
    logic [2:0]                  i_funct3;
    logic [`EXCEPTION_WIDTH-1:0] i_exception;
    logic                        i_change_pc;
    logic [31:0]                 i_next_pc;
    logic [1:0]                  i_addr_lsb;
    logic [31:0]                 i_load_data;
    logic                        i_ack;
    logic                        o_wr_rd;
    logic [4:0]                  o_rd_addr;
    logic [31:0]                 o_rd;
    logic                        o_change_pc;
    logic [31:0]                 o_next_pc;
    logic                        o_flush;
    logic                        o_stall;
    logic                        o_trap;
    logic [31:0]                 o_instret;

    rv32i_writeback #(.TRAP_VECTOR(TRAP_VEC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_stall(i_stall), .i_flush(i_flush),
        .i_rd_addr(i_rd_addr), .i_rd(i_rd), .i_wr_rd(i_wr_rd), .i_rd_valid(i_rd_valid),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_exception(i_exception),
        .i_change_pc(i_change_pc), .i_next_pc(i_next_pc), .i_addr_lsb(i_addr_lsb),
        .i_load_data(i_load_data), .i_ack(i_ack),
        .o_wr_rd(o_wr_rd), .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_change_pc(o_change_pc),
        .o_next_pc(o_next_pc), .o_flush(o_flush), .o_stall(o_stall), .o_trap(o_trap),
        .o_instret(o_instret)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        redir;
        logic        trap;
        logic [31:0] pc;
        logic [31:0] instret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_instret = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                        input logic redir, input logic trap, input logic [31:0] pc);
        exp_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        e.redir = redir; e.trap = trap; e.pc = pc; e.instret = model_instret;
        exp_q.push_back(e);
    endtask

    // Sign/zero extension written as plain arithmetic on the selected lane.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                             input logic [31:0] word);
        logic [31:0] v;
        int          sh;
        v = word;
        if (f3 == 3'b000 || f3 == 3'b100) begin
            sh = 8 * int'(lsb);
            v  = (word >> sh) & 32'h0000_00FF;
            if (f3 == 3'b000 && v >= 32'h80) v = v - 32'h100;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
            sh = 16 * int'(lsb[1]);
            v  = (word >> sh) & 32'h0000_FFFF;
            if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h1_0000;
        end
        return v;
    endfunction

    // Monitor: an event is consumed in the first unstalled cycle it is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && !i_stall && (o_wr_rd || o_change_pc || o_trap || o_flush)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got wr=%b cpc=%b flush=%b trap=%b expected none (t=%0t)",
                             o_wr_rd, o_change_pc, o_flush, o_trap, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_rd", {31'd0, o_wr_rd}, {31'd0, e.wr});
                    if (e.wr) begin
                        check("rd_addr", {27'd0, o_rd_addr}, {27'd0, e.addr});
                        check("rd_data", o_rd, e.data);
                    end
                    check("change_pc", {31'd0, o_change_pc}, {31'd0, e.redir});
                    check("flush_out", {31'd0, o_flush}, {31'd0, e.redir});
                    check("trap", {31'd0, o_trap}, {31'd0, e.trap});
                    if (e.redir) check("next_pc", o_next_pc, e.pc);
                    check("instret", o_instret, e.instret);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_ce = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_ack = 1'b0;
        i_exception = '0; i_change_pc = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        clear_inputs();
        repeat (n) step();
    endtask

    function automatic logic [`OPCODE_WIDTH-1:0] alu_opcode();
        int bits[6] = '{0, 1, 5, 6, 7, 8};
        logic [`OPCODE_WIDTH-1:0] op;
        op = '0;
        op[bits[$urandom_range(0, 5)]] = 1'b1;
        return op;
    endfunction

    // Present one instruction and hold it until an unstalled edge accepts it.
    task automatic issue(input logic [`OPCODE_WIDTH-1:0] op, input logic [4:0] rd_addr,
                         input logic [31:0] rd, input logic wr_rd, input logic rd_valid,
                         input logic [`EXCEPTION_WIDTH-1:0] exc, input logic change_pc,
                         input logic [31:0] next_pc, input logic [2:0] f3,
                         input logic [1:0] lsb, input bit allow_stall);
        i_ce = 1'b1; i_flush = 1'b0; i_ack = 1'b0;
        i_opcode = op; i_rd_addr = rd_addr; i_rd = rd; i_wr_rd = wr_rd; i_rd_valid = rd_valid;
        i_exception = exc; i_change_pc = change_pc; i_next_pc = next_pc;
        i_funct3 = f3; i_addr_lsb = lsb;
        do begin
            i_stall = allow_stall && ($urandom_range(0, 3) == 0);
            step();
        end while (i_stall);
        i_ce = 1'b0; i_stall = 1'b0; i_exception = '0; i_change_pc = 1'b0;
    endtask

    task automatic do_alu(input logic [4:0] rd_addr, input logic [31:0] data, input logic wr_rd,
                          input logic rd_valid, input logic jump, input logic [31:0] next_pc,
                          input bit allow_stall);
        logic [`OPCODE_WIDTH-1:0] op;
        logic                     we;
        op = alu_opcode();
        if (jump) begin
            op = '0;
            op[`JAL] = 1'b1;
        end
        issue(op, rd_addr, data, wr_rd, rd_valid, '0, jump, next_pc, 3'd0, 2'd0, allow_stall);
        model_instret = model_instret + 32'd1;
        we = wr_rd && rd_valid && (rd_addr != 5'd0);
        if (we || jump) push(we, rd_addr, data, jump, 1'b0, next_pc);
        if (jump) step();
    endtask

    task automatic do_exc(input logic [4:0] rd_addr, input logic [`EXCEPTION_WIDTH-1:0] exc,
                          input logic as_load, input bit allow_stall);
        logic [`OPCODE_WIDTH-1:0] op;
        op = alu_opcode();
        if (as_load) begin
            op = '0;
            op[`LOAD] = 1'b1;
        end
        issue(op, rd_addr, $urandom, 1'b1, 1'b1, exc, $urandom_range(0, 1) == 1, $urandom,
              3'd0, 2'd0, allow_stall);
        push(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, TRAP_VEC);
        step();
    endtask

    // flush_at = 0 lets the load complete; otherwise flush on that wait cycle.
    task automatic do_load(input logic [4:0] rd_addr, input logic [2:0] f3, input logic [1:0] lsb,
                           input logic [31:0] word, input int latency, input int flush_at,
                           input logic flush_with_ack, input bit allow_stall);
        logic [`OPCODE_WIDTH-1:0] op;
        op = '0;
        op[`LOAD] = 1'b1;
        issue(op, rd_addr, $urandom, 1'b1, 1'b0, '0, 1'b0, 32'd0, f3, lsb, allow_stall);
        for (int c = 1; c <= latency; c++) begin
            check("load_stall", {31'd0, o_stall}, 32'd1);
            if (c == flush_at) begin
                i_flush = 1'b1; i_ack = flush_with_ack; i_load_data = word;
                step();
                i_flush = 1'b0;
                check("stall_after_flush", {31'd0, o_stall}, 32'd0);
                i_ack = 1'b1;
                step();
                i_ack = 1'b0;
                return;
            end
            i_ack = (c == latency);
            i_load_data = (c == latency) ? word : $urandom;
            step();
        end
        i_ack = 1'b0;
        model_instret = model_instret + 32'd1;
        if (rd_addr != 5'd0) push(1'b1, rd_addr, ref_load(f3, lsb, word), 1'b0, 1'b0, 32'd0);
        check("stall_after_ack", {31'd0, o_stall}, 32'd0);
    endtask

    initial begin
        logic [2:0] f3;
        logic [1:0] lsb;
        int         lat;
        int         kind;
        int         f3_pick[5] = '{0, 1, 2, 4, 5};

        i_rst = 1'b1;
        clear_inputs();
        i_rd_addr = '0; i_rd = '0; i_wr_rd = 1'b0; i_rd_valid = 1'b0; i_opcode = '0;
        i_funct3 = '0; i_next_pc = '0; i_addr_lsb = '0; i_load_data = '0;
        repeat (2) step();
        check("rst_wr_rd", {31'd0, o_wr_rd}, 32'd0);
        check("rst_change_pc", {31'd0, o_change_pc}, 32'd0);
        check("rst_flush", {31'd0, o_flush}, 32'd0);
        check("rst_trap", {31'd0, o_trap}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_rd_addr", {27'd0, o_rd_addr}, 32'd0);
        check("rst_rd", o_rd, 32'd0);
        check("rst_next_pc", o_next_pc, 32'd0);
        check("rst_instret", o_instret, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step();

        do_alu(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        do_load(5'd10, 3'b000, 2'b11, 32'h80FF_0000, 3, 0, 1'b0, 1'b0);
        do_exc(5'd7, 4'b0010, 1'b0, 1'b0);
        do_alu(5'd1, 32'h0000_0044, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        do_load(5'd12, 3'b010, 2'b00, 32'h1234_5678, 2, 2, 1'b1, 1'b0);
        do_alu(5'd0, 32'h5555_AAAA, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        do_load(5'd3, 3'b101, 2'b10, 32'h9ABC_1234, 1, 0, 1'b0, 1'b0);
        do_load(5'd4, 3'b001, 2'b10, 32'h9ABC_1234, 4, 0, 1'b0, 1'b0);
        idle_cycles(2);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                do_alu($urandom_range(0, 5) == 0 ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
                       $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 1'b0, 32'd0, 1'b1);
            end else if (kind == 4) begin
                do_alu(5'($urandom_range(0, 31)), $urandom, 1'b1, 1'b1, 1'b1, $urandom, 1'b1);
            end else if (kind == 5) begin
                do_exc(5'($urandom_range(0, 31)), 4'($urandom_range(1, 15)),
                       $urandom_range(0, 1) == 1, 1'b1);
            end else if (kind <= 7) begin
                f3  = 3'(f3_pick[$urandom_range(0, 4)]);
                lsb = 2'($urandom_range(0, 3));
                if (f3 == 3'b001 || f3 == 3'b101) lsb[0] = 1'b0;
                if (f3 == 3'b010) lsb = 2'b00;
                lat = $urandom_range(1, 4);
                if ($urandom_range(0, 5) == 0)
                    do_load(5'($urandom_range(0, 31)), f3, lsb, $urandom, lat,
                            $urandom_range(1, lat), $urandom_range(0, 1) == 1, 1'b1);
                else
                    do_load(5'($urandom_range(0, 31)), f3, lsb, $urandom, lat, 0, 1'b0, 1'b1);
            end else if (kind == 8) begin
                i_opcode = alu_opcode(); i_rd_addr = 5'($urandom_range(1, 31)); i_rd = $urandom;
                i_wr_rd = 1'b1; i_rd_valid = 1'b1; i_change_pc = $urandom_range(0, 1) == 1;
                i_ce = 1'b1; i_flush = 1'b1; i_stall = 1'b0;
                step();
                clear_inputs();
            end else begin
                i_ce = 1'b0; i_stall = $urandom_range(0, 1) == 1;
                step();
                i_stall = 1'b0;
            end
        end
        idle_cycles(3);
        check("queue_drained", exp_q.size(), 32'd0);
        check("instret_total", o_instret, model_instret);

        force dut.r_instret = 32'hFFFF_FFFE;
        step();
        release dut.r_instret;
        model_instret = 32'hFFFF_FFFE;
        do_alu(5'd9, 32'h0000_1111, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        do_alu(5'd9, 32'h0000_2222, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        idle_cycles(2);
        check("instret_wrapped", o_instret, 32'd0);
        check("queue_drained_wrap", exp_q.size(), 32'd0);

        issue(32'(1 << `LOAD), 5'd8, 32'd0, 1'b1, 1'b0, '0, 1'b0, 32'd0, 3'b010, 2'b00, 1'b0);
        check("load_stall_pre_reset", {31'd0, o_stall}, 32'd1);
        #2 i_rst = 1'b1;
        #1;
        check("mid_rst_wr_rd", {31'd0, o_wr_rd}, 32'd0);
        check("mid_rst_stall", {31'd0, o_stall}, 32'd0);
        check("mid_rst_change_pc", {31'd0, o_change_pc}, 32'd0);
        check("mid_rst_flush", {31'd0, o_flush}, 32'd0);
        check("mid_rst_trap", {31'd0, o_trap}, 32'd0);
        check("mid_rst_rd_addr", {27'd0, o_rd_addr}, 32'd0);
        check("mid_rst_rd", o_rd, 32'd0);
        check("mid_rst_next_pc", o_next_pc, 32'd0);
        check("mid_rst_instret", o_instret, 32'd0);
        model_instret = 32'd0;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_ack = 1'b1; i_load_data = 32'hCAFE_F00D;
        for (int k = 0; k < 2; k++) begin
            step();
            check("post_rst_no_write", {31'd0, o_wr_rd}, 32'd0);
            check("post_rst_instret", o_instret, model_instret);
        end
        idle_cycles(2);
        check("queue_drained_final", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
